// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - two-port (instruction/data) round-robin arbiter in front of a single on-chip BRAM
module bram_arbiter #(
   parameter int RD_LAT = 1
) (
   input  logic        clk_clk,
   input  logic        reset_reset,

   input  logic        i_valid,
   output logic        i_ready,
   input  logic [9:0]  i_addr,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,

   input  logic        d_valid,
   output logic        d_ready,
   input  logic [9:0]  d_addr,
   input  logic        d_we,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   input  logic        d_lock,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,

   output logic [9:0]  onchip_memory_address,
   output logic        onchip_memory_chipselect,
   output logic        onchip_memory_clken,
   output logic        onchip_memory_write,
   output logic [31:0] onchip_memory_writedata,
   output logic [3:0]  onchip_memory_byteenable,
   input  logic [31:0] onchip_memory_readdata
);

   // lock_q: data port owns the memory for a read-modify-write sequence
   logic lock_q;
   // prio_d_q: 1 when the data port wins the next contention, 0 for instruction
   logic prio_d_q;

   logic grant_i;
   logic grant_d;
   logic rd_accept;

   // In-flight read tracker: one valid bit and one owner bit (1 = data) per latency stage
   logic [RD_LAT-1:0] pipe_vld;
   logic [RD_LAT-1:0] pipe_own;

   // Grant selection: reset blocks everything, a held lock excludes the instruction port,
   // contention is settled by the round-robin priority bit
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (!reset_reset) begin
         if (lock_q) begin
            grant_d = d_valid;
         end else if (i_valid && d_valid) begin
            grant_d = prio_d_q;
            grant_i = !prio_d_q;
         end else begin
            grant_i = i_valid;
            grant_d = d_valid;
         end
      end
   end

   assign rd_accept = grant_i | (grant_d & ~d_we);

   // Priority flips to the other port after every grant; lock follows d_lock while granted/held
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         lock_q   <= 1'b0;
         prio_d_q <= 1'b0;
      end else begin
         if (grant_i) begin
            prio_d_q <= 1'b1;
         end else if (grant_d) begin
            prio_d_q <= 1'b0;
         end
         if (grant_d && d_lock) begin
            lock_q <= 1'b1;
         end else if (!d_lock) begin
            lock_q <= 1'b0;
         end
      end
   end

   // Shift accepted reads down the latency pipeline; reset drops anything in flight
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         pipe_vld <= '0;
         pipe_own <= '0;
      end else begin
         pipe_vld[0] <= rd_accept;
         pipe_own[0] <= grant_d;
         for (int k = 1; k < RD_LAT; k++) begin
            pipe_vld[k] <= pipe_vld[k-1];
            pipe_own[k] <= pipe_own[k-1];
         end
      end
   end

   assign i_ready = grant_i;
   assign d_ready = grant_d;

   // Only the last stage is visible; a single owner bit makes both rvalids mutually exclusive
   assign i_rvalid = !reset_reset && pipe_vld[RD_LAT-1] && !pipe_own[RD_LAT-1];
   assign d_rvalid = !reset_reset && pipe_vld[RD_LAT-1] &&  pipe_own[RD_LAT-1];
   assign i_rdata  = onchip_memory_readdata;
   assign d_rdata  = onchip_memory_readdata;

   assign onchip_memory_clken      = 1'b1;
   assign onchip_memory_chipselect = grant_i | grant_d;
   assign onchip_memory_write      = grant_d & d_we;
   assign onchip_memory_address    = grant_d ? d_addr : (grant_i ? i_addr : 10'd0);
   assign onchip_memory_writedata  = grant_d ? d_wdata : 32'd0;
   assign onchip_memory_byteenable = (grant_d && d_we) ? d_be :
                                     ((grant_i || grant_d) ? 4'hF : 4'h0);

endmodule
